// File: rtl/srl_pkg.sv
// SR latch bank shared definitions: conflict-mode codes and the per-channel next-state function.
// Latency: none (pure functions). Backpressure: not applicable.
// SRL_TOGGLE_EN is handled in sr_cell; next_q always describes the non-toggle policy.
package srl_pkg;

   localparam int MODE_HOLD        = 0;
   localparam int MODE_SET_WINS    = 1;
   localparam int MODE_RESET_WINS  = 2;
   localparam int MODE_REPEAT_LAST = 3;

   // Next q for an enabled channel; the S=R=1 branch follows the conflict policy.
   function automatic logic next_q(input logic q, input logic last_op,
                                   input logic s, input logic r, input int mode);
      logic nq;
      nq = q;
      case ({s, r})
         2'b10: nq = 1'b1;
         2'b01: nq = 1'b0;
         2'b00: nq = q;
         default: begin
            case (mode)
               MODE_SET_WINS:    nq = 1'b1;
               MODE_RESET_WINS:  nq = 1'b0;
               MODE_REPEAT_LAST: nq = last_op;
               default:          nq = q;
            endcase
         end
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Bundle of per-channel command/status signals for sr_latch_bank.
// Latency: wires only. Backpressure: none; commands are sampled every cycle.
interface sr_latch_bank_if #(
   parameter int N     = 8,
   parameter int CNT_W = 8
);
   logic [N-1:0]     en;
   logic [N-1:0]     s;
   logic [N-1:0]     r;
   logic             clr_err;
   logic [N-1:0]     q;
   logic [N-1:0]     qn;
   logic [N-1:0]     conf;
   logic             err_sticky;
   logic [CNT_W-1:0] conf_cnt;

   modport master (
      output en, s, r, clr_err,
      input  q, qn, conf, err_sticky, conf_cnt
   );

   modport slave (
      input  en, s, r, clr_err,
      output q, qn, conf, err_sticky, conf_cnt
   );
endinterface

// File: rtl/sr_cell.sv
// One synchronous SR channel: q, last_op memory and the enabled-conflict term.
// Latency: 1 cycle s/r/en to q. Backpressure: none; disabled channel simply holds.
// With SRL_TOGGLE_EN defined, S=R=1 toggles q and is not reported as a conflict.
module sr_cell
   import srl_pkg::*;
#(
   parameter int   MODE    = MODE_HOLD,
   parameter logic RESET_Q = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic s,
   input  logic r,
   output logic q,
   output logic conf_term
);

   logic last_op;
   logic q_nxt;
   logic last_op_nxt;

   always_comb begin
      q_nxt       = q;
      last_op_nxt = last_op;
      conf_term   = 1'b0;
      if (en) begin
`ifdef SRL_TOGGLE_EN
         q_nxt = (s && r) ? ~q : next_q(q, last_op, s, r, MODE);
`else
         q_nxt     = next_q(q, last_op, s, r, MODE);
         conf_term = s & r;
`endif
         // Only an unambiguous command is remembered; conflicts leave last_op alone.
         if (s && !r)
            last_op_nxt = 1'b1;
         else if (r && !s)
            last_op_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= RESET_Q;
         last_op <= 1'b0;
      end else begin
         q       <= q_nxt;
         last_op <= last_op_nxt;
      end
   end

endmodule

// File: rtl/sr_latch_bank.sv
// N-channel clocked SR register bank with conflict pulse, sticky flag and saturating counter.
// Latency: 1 cycle for q/qn/conf/status. Backpressure: none. Optional macro: SRL_TOGGLE_EN.
module sr_latch_bank
   import srl_pkg::*;
#(
   parameter int             N             = 8,
   parameter int             CONFLICT_MODE = MODE_HOLD,
   parameter int             CNT_W         = 8,
   parameter logic [N-1:0]   RESET_VAL     = '0
) (
   input  logic         clk,
   input  logic         reset,
   sr_latch_bank_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [N-1:0]     q_int;
   logic [N-1:0]     conf_term;
   logic [N-1:0]     conf_q;
   logic             any_conf;
   logic             sticky_q;
   logic             sticky_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_nxt;

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_cell #(
         .MODE    (CONFLICT_MODE),
         .RESET_Q (RESET_VAL[i])
      ) u_cell (
         .clk       (clk),
         .reset     (reset),
         .en        (bus.en[i]),
         .s         (bus.s[i]),
         .r         (bus.r[i]),
         .q         (q_int[i]),
         .conf_term (conf_term[i])
      );
   end

   assign any_conf = |conf_term;

   // Clear acts on the old value first, so a same-cycle conflict still lands as count 1.
   always_comb begin
      cnt_base   = bus.clr_err ? '0 : cnt_q;
      cnt_nxt    = cnt_base;
      sticky_nxt = sticky_q & ~bus.clr_err;
      if (any_conf) begin
         sticky_nxt = 1'b1;
         if (cnt_base != CNT_MAX)
            cnt_nxt = cnt_base + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         conf_q   <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         conf_q   <= conf_term;
         sticky_q <= sticky_nxt;
         cnt_q    <= cnt_nxt;
      end
   end

   assign bus.q          = q_int;
   assign bus.qn         = ~q_int;
   assign bus.conf       = conf_q;
   assign bus.err_sticky = sticky_q;
   assign bus.conf_cnt   = cnt_q;

endmodule
